// File: rtl/oled_pkg.sv
// Shared definitions for the OLED serial link: command codes, decoder states
// and the colour constants also used by the transmitter side.
package oled_pkg;

  // Command bytes (sent with DnC = 0)
  localparam logic [7:0] SetX     = 8'h15;
  localparam logic [7:0] SetY     = 8'h75;
  localparam logic [7:0] SetPixel = 8'h5C;

  // RGB565 colours shared with the OLED manager
  localparam logic [15:0] ColourBlue  = 16'h001F;
  localparam logic [15:0] ColourWhite = 16'hFFFF;

  // Command/data decoder states
  typedef enum logic [2:0] {
    Idle,
    ColStart,
    ColEnd,
    RowStart,
    RowEnd,
    PixHi,
    PixLo
  } dec_state_t;

endpackage

// File: rtl/oled_spi_deserialiser.sv
// Oversampled SPI byte receiver: detects SCLK rising edges on the system clock,
// shifts SDIN in MSB first and flags the strobe that completes each byte.
module oled_spi_deserialiser
  import oled_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       dnc,
  input  logic       sdin,
  input  logic       sclk,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dnc
);

  logic       sclk_q;
  logic [2:0] bit_cnt;
  // Only the seven oldest bits need storing; the eighth arrives on the completing strobe.
  logic [6:0] shift;
  logic       strobe;

  assign strobe = sclk & ~sclk_q & ~cs_n;

  // Edge history, shift register and bit count; a deselect drops any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      sclk_q <= sclk;
      if (cs_n) begin
        bit_cnt <= '0;
      end else if (strobe) begin
        shift   <= {shift[5:0], sdin};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // The byte is presented combinationally in its completing strobe cycle so the
  // decoder acts on the same clock edge.
  assign byte_valid = strobe && (bit_cnt == 3'd7);
  assign byte_data  = {shift, sdin};
  assign byte_dnc   = dnc;

endmodule

// File: rtl/oled_receiver.sv
// Display-side model of the OLED link: decodes SetX/SetY/SetPixel sequences,
// tracks the column/row window and emits one registered pixel write per colour pair.
module oled_receiver
  import oled_pkg::*;
#(
  parameter int XWidth = 7,
  parameter int YWidth = 7,
  parameter int ColMax = 127,
  parameter int RowMax = 127
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              nCS,
  input  logic              DnC,
  input  logic              SDIN,
  input  logic              SCLK,
  output logic              pix_valid,
  output logic [XWidth-1:0] pix_x,
  output logic [YWidth-1:0] pix_y,
  output logic [15:0]       pix_data,
  output logic              window_done,
  output logic              cmd_err,
  output logic              stray_data
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dnc;

  oled_spi_deserialiser u_deser (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .cs_n       (nCS),
    .dnc        (DnC),
    .sdin       (SDIN),
    .sclk       (SCLK),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dnc   (byte_dnc)
  );

  dec_state_t        state, next_state;
  logic [XWidth-1:0] col_start, col_end, cur_x, next_x;
  logic [YWidth-1:0] row_start, row_end, cur_y, next_y;
  logic [7:0]        hi;
  logic              pix_fire, err_fire, stray_fire, known_cmd, at_col_end, at_end;

  // Decoder state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= Idle;
    else          state <= next_state;
  end

  // Next state: a command byte always overrides the current sequence
  always_comb begin
    next_state = state;
    if (byte_valid) begin
      if (!byte_dnc) begin
        case (byte_data)
          SetX:     next_state = ColStart;
          SetY:     next_state = RowStart;
          SetPixel: next_state = PixHi;
          default:  next_state = Idle;
        endcase
      end else begin
        case (state)
          ColStart: next_state = ColEnd;
          RowStart: next_state = RowEnd;
          PixHi:    next_state = PixLo;
          PixLo:    next_state = PixHi;
          default:  next_state = Idle;
        endcase
      end
    end
  end

  // Event decode for the registered pulse outputs
  always_comb begin
    known_cmd  = (byte_data == SetX) || (byte_data == SetY) || (byte_data == SetPixel);
    pix_fire   = byte_valid && byte_dnc && (state == PixLo);
    stray_fire = byte_valid && byte_dnc && (state == Idle);
    err_fire   = byte_valid && !byte_dnc && !known_cmd;
  end

  // Raster advance: wrap to col_start at col_end, stepping the row the same way.
  // Plain modular increment makes end<start windows wrap through the maximum.
  assign at_col_end = (cur_x == col_end);
  assign at_end     = at_col_end && (cur_y == row_end);
  assign next_x     = at_col_end ? col_start : cur_x + XWidth'(1);
  assign next_y     = !at_col_end ? cur_y :
                      (cur_y == row_end) ? row_start : cur_y + YWidth'(1);

  // Window registers, raster position and registered outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_start   <= '0;
      col_end     <= XWidth'(ColMax);
      row_start   <= '0;
      row_end     <= YWidth'(RowMax);
      cur_x       <= '0;
      cur_y       <= '0;
      hi          <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      window_done <= 1'b0;
      cmd_err     <= 1'b0;
      stray_data  <= 1'b0;
    end else begin
      pix_valid   <= pix_fire;
      window_done <= pix_fire && at_end;
      cmd_err     <= err_fire;
      stray_data  <= stray_fire;
      if (pix_fire) begin
        pix_x    <= cur_x;
        pix_y    <= cur_y;
        pix_data <= {hi, byte_data};
        cur_x    <= next_x;
        cur_y    <= next_y;
      end
      if (byte_valid && !byte_dnc && (byte_data == SetPixel)) begin
        cur_x <= col_start;
        cur_y <= row_start;
      end
      if (byte_valid && byte_dnc) begin
        case (state)
          ColStart: col_start <= byte_data[XWidth-1:0];
          ColEnd:   col_end   <= byte_data[XWidth-1:0];
          RowStart: row_start <= byte_data[YWidth-1:0];
          RowEnd:   row_end   <= byte_data[YWidth-1:0];
          PixHi:    hi        <= byte_data;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_receiver.sv
// Bench for oled_receiver: drives bytes over the oversampled serial link with
// random bit timing and checks every cycle against a protocol-level model.
module tb_oled_receiver;

  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic nCS = 1'b1, DnC = 1'b0, SDIN = 1'b0, SCLK = 1'b0;
  logic        pix_valid, window_done, cmd_err, stray_data;
  logic [6:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  oled_receiver dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .nCS(nCS), .DnC(DnC), .SDIN(SDIN), .SCLK(SCLK),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .window_done(window_done), .cmd_err(cmd_err), .stray_data(stray_data)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
    end
  endtask

  // ---------------- protocol model ----------------
  localparam int M_IDLE = 0, M_CS = 1, M_CE = 2, M_RS = 3, M_RE = 4, M_HI = 5, M_LO = 6;
  int m_st, m_cs, m_ce, m_rs, m_re, m_x, m_y, m_hi;
  int exp_cyc = -1;
  bit exp_valid, exp_done, exp_err, exp_stray;
  int exp_x, exp_y, exp_d;

  task automatic model_reset();
    m_st = M_IDLE; m_cs = 0; m_ce = 127; m_rs = 0; m_re = 127;
    m_x = 0; m_y = 0; m_hi = 0; exp_cyc = -1;
  endtask

  // Called when the completing SCLK edge is driven; the effect is due one cycle later.
  task automatic model_byte(input logic [7:0] b, input logic dc);
    int v;
    v = int'(b);
    exp_valid = 0; exp_done = 0; exp_err = 0; exp_stray = 0;
    if (!dc) begin
      if (v == 'h15)      m_st = M_CS;
      else if (v == 'h75) m_st = M_RS;
      else if (v == 'h5C) begin m_st = M_HI; m_x = m_cs; m_y = m_rs; end
      else begin m_st = M_IDLE; exp_err = 1; end
    end else begin
      case (m_st)
        M_IDLE: exp_stray = 1;
        M_CS: begin m_cs = v % 128; m_st = M_CE;   end
        M_CE: begin m_ce = v % 128; m_st = M_IDLE; end
        M_RS: begin m_rs = v % 128; m_st = M_RE;   end
        M_RE: begin m_re = v % 128; m_st = M_IDLE; end
        M_HI: begin m_hi = v;       m_st = M_LO;   end
        default: begin
          exp_valid = 1; exp_x = m_x; exp_y = m_y; exp_d = m_hi * 256 + v;
          exp_done = (m_x == m_ce) && (m_y == m_re);
          if (m_x == m_ce) begin
            m_x = m_cs;
            m_y = (m_y == m_re) ? m_rs : (m_y + 1) % 128;
          end else begin
            m_x = (m_x + 1) % 128;
          end
          m_st = M_HI;
        end
      endcase
    end
    exp_cyc = cyc + 1;
  endtask

  // ---------------- per-cycle compare and event log ----------------
  bit run = 0, hit;
  int pix_cnt = 0, err_cnt = 0, stray_cnt = 0, done_cnt = 0;
  int last_x = 0, last_y = 0, last_d = 0, last_wd = 0;

  always @(negedge HCLK) begin
    if (run) begin
      if (!HRESETn) begin
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_window_done", window_done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_stray_data", stray_data, 0);
        chk("rst_pix_fields", {pix_x, pix_y, pix_data}, 0);
      end else begin
        hit = (cyc == exp_cyc);
        chk("pix_valid", pix_valid, hit ? exp_valid : 0);
        chk("window_done", window_done, hit ? exp_done : 0);
        chk("cmd_err", cmd_err, hit ? exp_err : 0);
        chk("stray_data", stray_data, hit ? exp_stray : 0);
        if (hit && exp_valid) begin
          chk("pix_x", pix_x, exp_x);
          chk("pix_y", pix_y, exp_y);
          chk("pix_data", pix_data, exp_d);
        end
      end
      if (pix_valid) begin
        pix_cnt++; last_x = pix_x; last_y = pix_y; last_d = pix_data; last_wd = window_done;
      end
      if (window_done) done_cnt++;
      if (cmd_err)     err_cnt++;
      if (stray_data)  stray_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic dc, input int nbits);
    nCS = 1'b0; DnC = dc; tick(1);
    for (int i = 0; i < nbits; i++) begin
      SDIN = b[7-i]; SCLK = 1'b0; tick($urandom_range(1, 2));
      SCLK = 1'b1;
      if (i == 7) model_byte(b, dc);
      tick($urandom_range(1, 2));
    end
    SCLK = 1'b0; tick(1);
    nCS = 1'b1; tick(2);
  endtask

  task automatic cmd(input logic [7:0] b); send(b, 1'b0, 8); endtask
  task automatic dat(input logic [7:0] b); send(b, 1'b1, 8); endtask

  task automatic pixel_pair(); dat(8'($urandom)); dat(8'($urandom)); endtask

  int e0, s0, p0;

  initial begin
    model_reset();
    tick(3);
    run = 1;
    tick(2);
    HRESETn = 1'b1;
    tick(2);
    chk("reset_outputs", {pix_valid, window_done, cmd_err, stray_data}, 0);
    chk("reset_pix", {pix_x, pix_y, pix_data}, 0);

    // Window 14..21 x 31..43
    cmd(8'h15); dat(8'h0E); dat(8'h15);
    cmd(8'h75); dat(8'h1F); dat(8'h2B);
    chk("setup_no_pulses", pix_cnt + err_cnt + stray_cnt, 0);

    cmd(8'h5C); dat(8'h06); dat(8'h3C);
    chk("px1_count", pix_cnt, 1);
    chk("px1_x", last_x, 14);
    chk("px1_y", last_y, 31);
    chk("px1_data", last_d, 16'h063C);

    for (int k = 2; k <= 105; k++) begin
      pixel_pair();
      if (k == 9) begin
        chk("px9_x", last_x, 14); chk("px9_y", last_y, 32);
      end
      if (k == 103) chk("px103_no_done", done_cnt, 0);
      if (k == 104) begin
        chk("px104_x", last_x, 21); chk("px104_y", last_y, 43);
        chk("px104_done", last_wd, 1); chk("done_count", done_cnt, 1);
      end
      if (k == 105) begin
        chk("px105_x", last_x, 14); chk("px105_y", last_y, 31); chk("px105_done", last_wd, 0);
      end
    end

    // Partial byte dropped by nCS, then SetY decodes cleanly
    e0 = err_cnt;
    send(8'hA5, 1'b0, 5);
    cmd(8'h75);
    chk("abort_no_err", err_cnt, e0);
    dat(8'h1F); dat(8'h2B);

    // Unknown command, then stray data
    e0 = err_cnt; s0 = stray_cnt; p0 = pix_cnt;
    cmd(8'hAF);
    chk("bad_cmd_err", err_cnt, e0 + 1);
    dat(8'h12);
    chk("stray_count", stray_cnt, s0 + 1);
    chk("stray_no_pix", pix_cnt, p0);

    // Reset in the middle of the low colour byte
    cmd(8'h5C); dat(8'h81);
    nCS = 1'b0; DnC = 1'b1; tick(1);
    for (int i = 0; i < 4; i++) begin
      SDIN = i[0]; SCLK = 1'b0; tick(1); SCLK = 1'b1; tick(1);
    end
    #3 HRESETn = 1'b0;
    #1;
    chk("async_rst_pulses", {pix_valid, window_done, cmd_err, stray_data}, 0);
    chk("async_rst_pix", {pix_x, pix_y, pix_data}, 0);
    model_reset();
    SCLK = 1'b0; nCS = 1'b1;
    tick(3);
    HRESETn = 1'b1;
    tick(2);

    s0 = stray_cnt;
    dat(8'hFF);
    chk("post_rst_stray", stray_cnt, s0 + 1);

    // Default full window 0..127
    cmd(8'h5C);
    for (int k = 1; k <= 129; k++) begin
      pixel_pair();
      if (k == 1)   begin chk("full_px1_x", last_x, 0);     chk("full_px1_y", last_y, 0); end
      if (k == 128) begin chk("full_px128_x", last_x, 127); chk("full_px128_y", last_y, 0); end
      if (k == 129) begin chk("full_px129_x", last_x, 0);   chk("full_px129_y", last_y, 1); end
    end

    // Random traffic: commands, data, aborted bytes, arbitrary windows
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        send(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 7));
      end else if (r < 22) begin
        case ($urandom_range(0, 3))
          0:       c = 8'h15;
          1:       c = 8'h75;
          2:       c = 8'h5C;
          default: c = 8'($urandom);
        endcase
        cmd(c);
      end else begin
        dat(8'($urandom));
      end
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oled_receiver.md
Name: oled_receiver

Overview:
Synthesisable receiver for the 4-wire OLED serial link (nCS, DnC, SDIN, SCLK) driven by the chip's OLED manager. It deserialises bytes and decodes the SetX (0x15), SetY (0x75) and SetPixel (0x5C) command protocol. It tracks the column/row window and emits one 16-bit pixel write per received colour pair. It is used as an on-chip loopback/checker and as the display-side model in SoC benches. It runs on the same HCLK as the transmitter, so SCLK is oversampled, not used as a clock.

Parameters:
XWidth, 7, column coordinate width (0..127)
YWidth, 7, row coordinate width (0..127)
ColMax, 127, reset value of col_end
RowMax, 127, reset value of row_end

Ports:
HCLK  input  1  system clock; all logic on posedge
HRESETn  input  1  asynchronous active-low reset
nCS  input  1  chip select, active low
DnC  input  1  1 = data byte, 0 = command byte
SDIN  input  1  serial data, MSB first
SCLK  input  1  serial clock; sampled, rising edge is the data strobe
pix_valid  output  1  one-cycle pulse: pixel write
pix_x  output  XWidth  column of pixel write
pix_y  output  YWidth  row of pixel write
pix_data  output  16  colour {first byte, second byte}
window_done  output  1  pulse with the pixel written at (col_end,row_end)
cmd_err  output  1  pulse: unknown command byte
stray_data  output  1  pulse: data byte received in Idle

Behaviour:
- Reset: all outputs 0; sclk_q=0; bit_cnt=0; shift=0; state=Idle; col_start=0, col_end=ColMax, row_start=0, row_end=RowMax; cur_x=cur_y=0.
- Edge detect: sclk_q <= SCLK each cycle; strobe = SCLK & ~sclk_q & ~nCS. SDIN and DnC are sampled in the strobe cycle.
- On strobe: shift <= {shift[6:0],SDIN}; bit_cnt++.
- When bit_cnt==7 at strobe: the byte is complete, and its DnC is the DnC sampled at this strobe. Decoding happens at the same clock edge.
- All outputs are registered. A pixel, error or window pulse is high in the cycle after the completing strobe cycle, for exactly 1 cycle.
- nCS high resets bit_cnt to 0 and discards a partial byte. The decode state is kept, because nCS rises between every byte.
- Decoder FSM states: Idle, ColStart, ColEnd, RowStart, RowEnd, PixHi, PixLo.
- Any command byte, in any state:
  - 0x15 -> ColStart.
  - 0x75 -> RowStart.
  - 0x5C -> PixHi, and cur_x<=col_start, cur_y<=row_start.
  - Anything else -> Idle, with a cmd_err pulse.
  - A command always aborts an in-progress sequence.
- Data bytes:
  - ColStart: col_start<=byte[6:0] -> ColEnd.
  - ColEnd: col_end<=byte[6:0] -> Idle.
  - RowStart, RowEnd: same as the column pair, for rows.
  - PixHi: hi<=byte -> PixLo.
  - PixLo: emit pixel {hi,byte} at (cur_x,cur_y) -> PixHi.
  - Idle: byte ignored, stray_data pulse.
- Bit 7 of coordinate bytes is ignored.
- Address advance after each pixel:
  - If cur_x==col_end: cur_x<=col_start, and cur_y advances (cur_y==row_end ? row_start : cur_y+1).
  - Otherwise cur_x<=cur_x+1, mod 2^XWidth.
  - If end<start, the counter wraps through ColMax/0 until it reaches end. This is the same rule, stated explicitly.
- window_done is asserted together with pix_valid when the written pixel is (col_end,row_end). Streaming continues after it, wrapping to (col_start,row_start).
- Reset mid-byte or mid-sequence returns everything to reset values immediately (async). The first byte after reset is decoded from scratch.
- Back-to-back bytes are at least 16 HCLK apart by protocol. The receiver does not depend on a gap beyond one cycle between strobes.

Decomposition:
- Package oled_pkg: command constants SetX=8'h15, SetY=8'h75, SetPixel=8'h5C; the decoder state enum; the ColourBlue/ColourWhite constants shared with the transmitter.
- Sub-module oled_spi_deserialiser: edge detect, shift register and bit counter.
  - Outputs byte_valid, byte_data[7:0] and byte_dnc.
  - Decode and addressing stay in the top module.

Test Plan:
- Cmd 0x15, data 0x0E, 0x15 -> col window 14..21. Then cmd 0x75, data 0x1F, 0x2B -> rows 31..43. No pulses.
- Then 0x5C, data 0x06, 0x3C -> pix_valid with pix_x=14, pix_y=31, pix_data=0x063C, high 1 cycle after the 16th strobe.
- Stream 8 pixel pairs -> the 9th pixel is at (14,32).
- Stream 104 pairs (one 8x13 block) -> window_done on the 104th, at (21,43). The 105th pixel is at (14,31).
- Drop nCS high after 5 bits, then send 0x75 -> partial byte discarded, RowStart entered, no cmd_err.
- Cmd 0xAF -> cmd_err pulse, state Idle. A following data 0x12 -> stray_data pulse, no pix_valid.
- Assert HRESETn low mid-PixLo -> outputs 0 immediately. After release, data 0xFF -> stray_data; the windows are back at 0..127.
